// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI request scheduler.
//   - sched_state_e : scheduler FSM encoding (IDLE / ISSUE / BUSY)
//   - OWNER_*       : value held in the owner register and driven on inst_label
//   - RESP_CAUSE_TIMEOUT : cause code returned when a transaction is aborted
package qspi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } sched_state_e;

  localparam logic OWNER_CCHAN = 1'b0;
  localparam logic OWNER_DCHAN = 1'b1;

  localparam logic [1:0] RESP_CAUSE_TIMEOUT = 2'b11;

endpackage

// File: rtl/qspi_sched_arb.sv
// Priority arbiter between dchan and cchan with starvation protection.
// dchan normally wins; run_cnt counts consecutive dchan grants made while
// cchan is waiting, and once it reaches DCHAN_MAX_RUN cchan gets the next
// grant when both are requesting.
// Ports:
//   clock, reset              : clock and synchronous active-high reset
//   arb_en                    : grants may only be issued when high (FSM idle)
//   dchan_valid, cchan_valid  : request pending from each channel
//   grant_dchan, grant_cchan  : one-hot (or zero) combinational grant
module qspi_sched_arb #(
  parameter int DCHAN_MAX_RUN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic arb_en,
  input  logic dchan_valid,
  input  logic cchan_valid,
  output logic grant_dchan,
  output logic grant_cchan
);

  logic [3:0] run_cnt;
  logic       starve;

  always_comb begin
    starve      = dchan_valid && cchan_valid && (run_cnt == 4'(DCHAN_MAX_RUN));
    grant_dchan = arb_en && dchan_valid && !starve;
    grant_cchan = arb_en && cchan_valid && (!dchan_valid || starve);
  end

  // run_cnt only grows while cchan is actually being held off; any other
  // grant restarts the run.
  always_ff @(posedge clock) begin
    if (reset) begin
      run_cnt <= 4'd0;
    end else if (grant_cchan) begin
      run_cnt <= 4'd0;
    end else if (grant_dchan) begin
      if (cchan_valid) run_cnt <= (run_cnt == 4'd15) ? 4'd15 : run_cnt + 4'd1;
      else             run_cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/qspi_req_scheduler.sv
// Transaction-level scheduler sharing the QSPI instruction path between the
// data channel (dchan) and control channel (cchan).
// A grant in IDLE latches the winner's request and owner; the owner then
// keeps the tdata/rdata FIFO paths and the response until the flash response
// returns (or, with QSPI_SCHED_TIMEOUT_EN defined, until TIMEOUT_CYCLES BUSY
// cycles pass, which returns an error response and pulses io_flash_abort).
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   io_{d,c}chan_req_*           : channel requests, ready is a 1-cycle accept
//   io_flash_req_*               : registered request to the decoder
//   io_flash_resp_*              : decoder response, valid only meaningful in BUSY
//   io_{d,c}chan_resp_*          : registered response routed to the owner
//   io_{d,c}chan_tdata_fifo_*    : per-channel tx FIFO view, io_tdata_fifo_* shared
//   io_{d,c}chan_rdata_fifo_*    : per-channel rx FIFO view, io_rdata_fifo_* shared
//   io_flash_abort               : timeout pulse (QSPI_SCHED_TIMEOUT_EN only)
module qspi_req_scheduler
  import qspi_pkg::*;
#(
  parameter int DCHAN_MAX_RUN  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_dchan_req_valid,
  output logic        io_dchan_req_ready,
  input  logic [7:0]  io_dchan_req_inst,
  input  logic [7:0]  io_dchan_req_data_size,
  input  logic [7:0]  io_dchan_req_data_burstlen,
  input  logic [23:0] io_dchan_req_addr,
  input  logic        io_cchan_req_valid,
  output logic        io_cchan_req_ready,
  input  logic [7:0]  io_cchan_req_inst,
  input  logic [7:0]  io_cchan_req_data_size,
  input  logic [7:0]  io_cchan_req_data_burstlen,
  input  logic [23:0] io_cchan_req_addr,
  output logic        io_flash_req_valid,
  input  logic        io_flash_req_ready,
  output logic [7:0]  io_flash_req_inst,
  output logic [7:0]  io_flash_req_data_size,
  output logic [7:0]  io_flash_req_data_burstlen,
  output logic [23:0] io_flash_req_addr,
  output logic        io_flash_req_inst_label,
  input  logic        io_flash_resp_valid,
  input  logic        io_flash_resp_error,
  input  logic [1:0]  io_flash_resp_cause,
  output logic        io_dchan_resp_valid,
  output logic        io_dchan_resp_error,
  output logic [1:0]  io_dchan_resp_cause,
  output logic        io_cchan_resp_valid,
  output logic        io_cchan_resp_error,
  output logic [1:0]  io_cchan_resp_cause,
  input  logic        io_dchan_tdata_fifo_wen,
  input  logic [31:0] io_dchan_tdata_fifo_wdata,
  output logic        io_dchan_tdata_fifo_full,
  input  logic        io_cchan_tdata_fifo_wen,
  input  logic [31:0] io_cchan_tdata_fifo_wdata,
  output logic        io_cchan_tdata_fifo_full,
  output logic        io_tdata_fifo_wen,
  output logic [31:0] io_tdata_fifo_wdata,
  input  logic        io_tdata_fifo_full,
  input  logic        io_dchan_rdata_fifo_ren,
  output logic [31:0] io_dchan_rdata_fifo_rdata,
  output logic        io_dchan_rdata_fifo_empty,
  input  logic        io_cchan_rdata_fifo_ren,
  output logic [31:0] io_cchan_rdata_fifo_rdata,
  output logic        io_cchan_rdata_fifo_empty,
  output logic        io_rdata_fifo_ren,
  input  logic [31:0] io_rdata_fifo_rdata,
  input  logic        io_rdata_fifo_empty
`ifdef QSPI_SCHED_TIMEOUT_EN
  ,
  output logic        io_flash_abort
`endif
);

  sched_state_e state_q, state_d;
  logic         owner_q;
  logic         grant_dchan, grant_cchan, grant_any;
  logic         resp_fire, timeout_hit;
  logic         active, d_own, c_own;

  qspi_sched_arb #(.DCHAN_MAX_RUN(DCHAN_MAX_RUN)) u_arb (
    .clock       (clock),
    .reset       (reset),
    .arb_en      ((state_q == ST_IDLE) && !reset),
    .dchan_valid (io_dchan_req_valid),
    .cchan_valid (io_cchan_req_valid),
    .grant_dchan (grant_dchan),
    .grant_cchan (grant_cchan)
  );

  assign grant_any          = grant_dchan || grant_cchan;
  assign io_dchan_req_ready = grant_dchan;
  assign io_cchan_req_ready = grant_cchan;
  // A response outside BUSY is a protocol error and is dropped here.
  assign resp_fire          = (state_q == ST_BUSY) && io_flash_resp_valid;

`ifdef QSPI_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] tmo_cnt;

  // Counts BUSY cycles, restarting on every BUSY entry; a real response in
  // the final cycle takes precedence over the abort.
  assign timeout_hit = (state_q == ST_BUSY) && !io_flash_resp_valid &&
                       (tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt        <= '0;
      io_flash_abort <= 1'b0;
    end else begin
      io_flash_abort <= timeout_hit;
      if (state_q == ST_ISSUE && io_flash_req_ready) tmo_cnt <= '0;
      else if (state_q == ST_BUSY)                   tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_any) state_d = ST_ISSUE;
      ST_ISSUE: if (io_flash_req_ready) state_d = ST_BUSY;
      ST_BUSY:  if (resp_fire || timeout_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request latch, owner register and per-owner response routing.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q                    <= OWNER_CCHAN;
      io_flash_req_valid         <= 1'b0;
      io_flash_req_inst          <= 8'd0;
      io_flash_req_data_size     <= 8'd0;
      io_flash_req_data_burstlen <= 8'd0;
      io_flash_req_addr          <= 24'd0;
      io_dchan_resp_valid        <= 1'b0;
      io_dchan_resp_error        <= 1'b0;
      io_dchan_resp_cause        <= 2'd0;
      io_cchan_resp_valid        <= 1'b0;
      io_cchan_resp_error        <= 1'b0;
      io_cchan_resp_cause        <= 2'd0;
    end else begin
      io_dchan_resp_valid <= 1'b0;
      io_dchan_resp_error <= 1'b0;
      io_dchan_resp_cause <= 2'd0;
      io_cchan_resp_valid <= 1'b0;
      io_cchan_resp_error <= 1'b0;
      io_cchan_resp_cause <= 2'd0;
      if (grant_any) begin
        owner_q            <= grant_dchan ? OWNER_DCHAN : OWNER_CCHAN;
        io_flash_req_valid <= 1'b1;
        if (grant_dchan) begin
          io_flash_req_inst          <= io_dchan_req_inst;
          io_flash_req_data_size     <= io_dchan_req_data_size;
          io_flash_req_data_burstlen <= io_dchan_req_data_burstlen;
          io_flash_req_addr          <= io_dchan_req_addr;
        end else begin
          io_flash_req_inst          <= io_cchan_req_inst;
          io_flash_req_data_size     <= io_cchan_req_data_size;
          io_flash_req_data_burstlen <= io_cchan_req_data_burstlen;
          io_flash_req_addr          <= io_cchan_req_addr;
        end
      end
      if (state_q == ST_ISSUE && io_flash_req_ready) io_flash_req_valid <= 1'b0;
      if (resp_fire || timeout_hit) begin
        if (owner_q == OWNER_DCHAN) begin
          io_dchan_resp_valid <= 1'b1;
          io_dchan_resp_error <= resp_fire ? io_flash_resp_error : 1'b1;
          io_dchan_resp_cause <= resp_fire ? io_flash_resp_cause : RESP_CAUSE_TIMEOUT;
        end else begin
          io_cchan_resp_valid <= 1'b1;
          io_cchan_resp_error <= resp_fire ? io_flash_resp_error : 1'b1;
          io_cchan_resp_cause <= resp_fire ? io_flash_resp_cause : RESP_CAUSE_TIMEOUT;
        end
      end
    end
  end

  assign io_flash_req_inst_label = owner_q;

  // FIFO steering follows the latched owner for the whole transaction; the
  // non-owner (and both channels while idle) see a full/empty FIFO.
  assign active = (state_q != ST_IDLE);
  assign d_own  = active && (owner_q == OWNER_DCHAN);
  assign c_own  = active && (owner_q == OWNER_CCHAN);

  assign io_tdata_fifo_wen         = (d_own && io_dchan_tdata_fifo_wen) ||
                                     (c_own && io_cchan_tdata_fifo_wen);
  assign io_tdata_fifo_wdata       = d_own ? io_dchan_tdata_fifo_wdata :
                                     c_own ? io_cchan_tdata_fifo_wdata : 32'd0;
  assign io_dchan_tdata_fifo_full  = !d_own || io_tdata_fifo_full;
  assign io_cchan_tdata_fifo_full  = !c_own || io_tdata_fifo_full;

  assign io_rdata_fifo_ren         = (d_own && io_dchan_rdata_fifo_ren) ||
                                     (c_own && io_cchan_rdata_fifo_ren);
  assign io_dchan_rdata_fifo_rdata = io_rdata_fifo_rdata;
  assign io_cchan_rdata_fifo_rdata = io_rdata_fifo_rdata;
  assign io_dchan_rdata_fifo_empty = !d_own || io_rdata_fifo_empty;
  assign io_cchan_rdata_fifo_empty = !c_own || io_rdata_fifo_empty;

endmodule

// File: tb/tb_qspi_req_scheduler.sv
// Self-checking bench for qspi_req_scheduler. Inputs are driven 1 ns after
// the rising edge and outputs sampled 1 ns later. Arbitration expectations
// come from a small model of the grant rules (streak of dchan wins while
// cchan waits). Build with +define+QSPI_SCHED_TIMEOUT_EN to add the timeout
// scenarios (TIMEOUT_CYCLES = 8).
module tb_qspi_req_scheduler;

  localparam int MAX_RUN = 4;
  localparam int TMO     = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        io_dchan_req_valid, io_dchan_req_ready;
  logic [7:0]  io_dchan_req_inst, io_dchan_req_data_size, io_dchan_req_data_burstlen;
  logic [23:0] io_dchan_req_addr;
  logic        io_cchan_req_valid, io_cchan_req_ready;
  logic [7:0]  io_cchan_req_inst, io_cchan_req_data_size, io_cchan_req_data_burstlen;
  logic [23:0] io_cchan_req_addr;
  logic        io_flash_req_valid, io_flash_req_ready;
  logic [7:0]  io_flash_req_inst, io_flash_req_data_size, io_flash_req_data_burstlen;
  logic [23:0] io_flash_req_addr;
  logic        io_flash_req_inst_label;
  logic        io_flash_resp_valid, io_flash_resp_error;
  logic [1:0]  io_flash_resp_cause;
  logic        io_dchan_resp_valid, io_dchan_resp_error;
  logic [1:0]  io_dchan_resp_cause;
  logic        io_cchan_resp_valid, io_cchan_resp_error;
  logic [1:0]  io_cchan_resp_cause;
  logic        io_dchan_tdata_fifo_wen, io_dchan_tdata_fifo_full;
  logic [31:0] io_dchan_tdata_fifo_wdata;
  logic        io_cchan_tdata_fifo_wen, io_cchan_tdata_fifo_full;
  logic [31:0] io_cchan_tdata_fifo_wdata;
  logic        io_tdata_fifo_wen, io_tdata_fifo_full;
  logic [31:0] io_tdata_fifo_wdata;
  logic        io_dchan_rdata_fifo_ren, io_dchan_rdata_fifo_empty;
  logic [31:0] io_dchan_rdata_fifo_rdata;
  logic        io_cchan_rdata_fifo_ren, io_cchan_rdata_fifo_empty;
  logic [31:0] io_cchan_rdata_fifo_rdata;
  logic        io_rdata_fifo_ren, io_rdata_fifo_empty;
  logic [31:0] io_rdata_fifo_rdata;
`ifdef QSPI_SCHED_TIMEOUT_EN
  logic        io_flash_abort;
`endif

  qspi_req_scheduler #(.DCHAN_MAX_RUN(MAX_RUN), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .io_dchan_req_valid(io_dchan_req_valid), .io_dchan_req_ready(io_dchan_req_ready),
    .io_dchan_req_inst(io_dchan_req_inst), .io_dchan_req_data_size(io_dchan_req_data_size),
    .io_dchan_req_data_burstlen(io_dchan_req_data_burstlen), .io_dchan_req_addr(io_dchan_req_addr),
    .io_cchan_req_valid(io_cchan_req_valid), .io_cchan_req_ready(io_cchan_req_ready),
    .io_cchan_req_inst(io_cchan_req_inst), .io_cchan_req_data_size(io_cchan_req_data_size),
    .io_cchan_req_data_burstlen(io_cchan_req_data_burstlen), .io_cchan_req_addr(io_cchan_req_addr),
    .io_flash_req_valid(io_flash_req_valid), .io_flash_req_ready(io_flash_req_ready),
    .io_flash_req_inst(io_flash_req_inst), .io_flash_req_data_size(io_flash_req_data_size),
    .io_flash_req_data_burstlen(io_flash_req_data_burstlen), .io_flash_req_addr(io_flash_req_addr),
    .io_flash_req_inst_label(io_flash_req_inst_label),
    .io_flash_resp_valid(io_flash_resp_valid), .io_flash_resp_error(io_flash_resp_error),
    .io_flash_resp_cause(io_flash_resp_cause),
    .io_dchan_resp_valid(io_dchan_resp_valid), .io_dchan_resp_error(io_dchan_resp_error),
    .io_dchan_resp_cause(io_dchan_resp_cause),
    .io_cchan_resp_valid(io_cchan_resp_valid), .io_cchan_resp_error(io_cchan_resp_error),
    .io_cchan_resp_cause(io_cchan_resp_cause),
    .io_dchan_tdata_fifo_wen(io_dchan_tdata_fifo_wen), .io_dchan_tdata_fifo_wdata(io_dchan_tdata_fifo_wdata),
    .io_dchan_tdata_fifo_full(io_dchan_tdata_fifo_full),
    .io_cchan_tdata_fifo_wen(io_cchan_tdata_fifo_wen), .io_cchan_tdata_fifo_wdata(io_cchan_tdata_fifo_wdata),
    .io_cchan_tdata_fifo_full(io_cchan_tdata_fifo_full),
    .io_tdata_fifo_wen(io_tdata_fifo_wen), .io_tdata_fifo_wdata(io_tdata_fifo_wdata),
    .io_tdata_fifo_full(io_tdata_fifo_full),
    .io_dchan_rdata_fifo_ren(io_dchan_rdata_fifo_ren), .io_dchan_rdata_fifo_rdata(io_dchan_rdata_fifo_rdata),
    .io_dchan_rdata_fifo_empty(io_dchan_rdata_fifo_empty),
    .io_cchan_rdata_fifo_ren(io_cchan_rdata_fifo_ren), .io_cchan_rdata_fifo_rdata(io_cchan_rdata_fifo_rdata),
    .io_cchan_rdata_fifo_empty(io_cchan_rdata_fifo_empty),
    .io_rdata_fifo_ren(io_rdata_fifo_ren), .io_rdata_fifo_rdata(io_rdata_fifo_rdata),
    .io_rdata_fifo_empty(io_rdata_fifo_empty)
`ifdef QSPI_SCHED_TIMEOUT_EN
    , .io_flash_abort(io_flash_abort)
`endif
  );

  int total = 0;
  int bad   = 0;
  int streak = 0;  // dchan wins in a row while cchan was also requesting

  // Grant rule: dchan first, unless it has already won MAX_RUN times in a
  // row against a waiting cchan. Returns 1 when dchan should win.
  function automatic bit model_pick(input bit dv, input bit cv);
    bit w;
    if (dv && cv) begin
      if (streak == MAX_RUN) begin w = 1'b0; streak = 0; end
      else begin w = 1'b1; if (streak < 15) streak = streak + 1; end
    end else begin
      w = dv;
      streak = 0;
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_d();
    io_dchan_req_inst = 8'($urandom); io_dchan_req_data_size = 8'($urandom);
    io_dchan_req_data_burstlen = 8'($urandom); io_dchan_req_addr = 24'($urandom);
  endtask

  task automatic rand_c();
    io_cchan_req_inst = 8'($urandom); io_cchan_req_data_size = 8'($urandom);
    io_cchan_req_data_burstlen = 8'($urandom); io_cchan_req_addr = 24'($urandom);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    io_dchan_req_valid = 0; io_cchan_req_valid = 0; io_flash_req_ready = 0;
    io_flash_resp_valid = 0; io_flash_resp_error = 0; io_flash_resp_cause = 0;
    io_dchan_tdata_fifo_wen = 0; io_cchan_tdata_fifo_wen = 0;
    io_dchan_tdata_fifo_wdata = 0; io_cchan_tdata_fifo_wdata = 0; io_tdata_fifo_full = 0;
    io_dchan_rdata_fifo_ren = 0; io_cchan_rdata_fifo_ren = 0;
    io_rdata_fifo_rdata = 0; io_rdata_fifo_empty = 0;
    rand_d(); rand_c();
    step(); step();
    reset = 1'b0;
    streak = 0;
  endtask

  // Packs every output that has a fixed reset value.
  function automatic logic [67:0] rst_obs();
    return {io_flash_req_valid, io_flash_req_inst, io_flash_req_data_size,
            io_flash_req_data_burstlen, io_flash_req_addr, io_flash_req_inst_label,
            io_dchan_resp_valid, io_dchan_resp_error, io_dchan_resp_cause,
            io_cchan_resp_valid, io_cchan_resp_error, io_cchan_resp_cause,
            io_dchan_req_ready, io_cchan_req_ready, io_tdata_fifo_wen, io_rdata_fifo_ren,
            io_dchan_tdata_fifo_full, io_cchan_tdata_fifo_full,
            io_dchan_rdata_fifo_empty, io_cchan_rdata_fifo_empty};
  endfunction

  localparam logic [67:0] RST_EXP = {64'd0, 4'b1111};

  function automatic logic [7:0] resp_obs();
    return {io_dchan_resp_valid, io_dchan_resp_error, io_dchan_resp_cause,
            io_cchan_resp_valid, io_cchan_resp_error, io_cchan_resp_cause};
  endfunction

  task automatic test_reset();
    apply_reset();
    #1;
    total++;
    if (rst_obs() !== RST_EXP) begin
      bad++; $display("FAIL reset_values got=%h want=%h", rst_obs(), RST_EXP);
    end
  endtask

  task automatic test_single_cchan();
    logic [7:0] sz;
    sz = 8'($urandom);
    io_cchan_req_valid = 1; io_cchan_req_inst = 8'h9F; io_cchan_req_addr = 24'h0;
    io_cchan_req_data_size = sz; io_cchan_req_data_burstlen = 8'h01;
    #1;
    void'(model_pick(1'b0, 1'b1));
    total++;
    if ({io_dchan_req_ready, io_cchan_req_ready} !== 2'b01) begin
      bad++; $display("FAIL single_grant got=%b want=01", {io_dchan_req_ready, io_cchan_req_ready});
    end
    step();
    io_cchan_req_valid = 0;
    #1;
    total++;
    if ({io_flash_req_valid, io_flash_req_inst, io_flash_req_addr, io_flash_req_data_size, io_flash_req_inst_label, io_cchan_req_ready}
        !== {1'b1, 8'h9F, 24'h0, sz, 1'b0, 1'b0}) begin
      bad++; $display("FAIL single_req got v=%b inst=%h addr=%h sz=%h lbl=%b want v=1 inst=9f addr=0 sz=%h lbl=0",
                      io_flash_req_valid, io_flash_req_inst, io_flash_req_addr, io_flash_req_data_size, io_flash_req_inst_label, sz);
    end
    io_flash_req_ready = 1;
    step();
    io_flash_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({io_flash_req_valid, io_dchan_resp_valid, io_cchan_resp_valid} !== 3'b000) begin
        bad++; $display("FAIL single_busy_quiet got=%b want=000", {io_flash_req_valid, io_dchan_resp_valid, io_cchan_resp_valid});
      end
    end
    io_flash_resp_valid = 1; io_flash_resp_error = 0; io_flash_resp_cause = 2'b00;
    step();
    io_flash_resp_valid = 0;
    #1;
    total++;
    if ({io_cchan_resp_valid, io_dchan_resp_valid} !== 2'b10) begin
      bad++; $display("FAIL single_resp got c=%b d=%b want c=1 d=0", io_cchan_resp_valid, io_dchan_resp_valid);
    end
    step();
    total++;
    if (io_cchan_resp_valid !== 1'b0) begin
      bad++; $display("FAIL single_resp_pulse got=%b want=0", io_cchan_resp_valid);
    end
  endtask

  // Full transactions back to back; each grant checked against the model,
  // and in fixed mode also against the literal d,d,d,d,c,... order.
  task automatic test_arbitration(input bit randomize_valids, input int n_txn);
    logic [9:0] pat;
    bit dv, cv, w, er;
    logic [1:0] ca;
    logic [48:0] exp_req;
    logic [7:0]  exp_resp;
    pat = 10'b1111011110;
    for (int t = 0; t < n_txn; t++) begin
      if (randomize_valids) begin
        dv = 1'($urandom); cv = 1'($urandom);
        if (!dv && !cv) begin
          io_dchan_req_valid = 0; io_cchan_req_valid = 0;
          #1;
          total++;
          if ({io_dchan_req_ready, io_cchan_req_ready} !== 2'b00) begin
            bad++; $display("FAIL arb_no_req got=%b want=00", {io_dchan_req_ready, io_cchan_req_ready});
          end
          step();
          if ($urandom_range(1, 0) == 1) dv = 1; else cv = 1;
        end
      end else begin
        dv = 1; cv = 1;
      end
      io_dchan_req_valid = dv; io_cchan_req_valid = cv;
      #1;
      w = model_pick(dv, cv);
      total++;
      if ({io_dchan_req_ready, io_cchan_req_ready} !== {w, !w}) begin
        bad++; $display("FAIL arb_grant t=%0d got=%b want=%b", t, {io_dchan_req_ready, io_cchan_req_ready}, {w, !w});
      end
      if (!randomize_valids && t < 10) begin
        total++;
        if (io_dchan_req_ready !== pat[9-t]) begin
          bad++; $display("FAIL arb_order t=%0d got_d=%b want_d=%b", t, io_dchan_req_ready, pat[9-t]);
        end
      end
      exp_req = w ? {io_dchan_req_inst, io_dchan_req_data_size, io_dchan_req_data_burstlen, io_dchan_req_addr, 1'b1}
                  : {io_cchan_req_inst, io_cchan_req_data_size, io_cchan_req_data_burstlen, io_cchan_req_addr, 1'b0};
      step();
      if (w) rand_d(); else rand_c();
      #1;
      total++;
      if ({io_flash_req_valid, io_flash_req_inst, io_flash_req_data_size, io_flash_req_data_burstlen, io_flash_req_addr, io_flash_req_inst_label}
          !== {1'b1, exp_req}) begin
        bad++; $display("FAIL arb_req t=%0d got=%h want=%h", t,
          {io_flash_req_valid, io_flash_req_inst, io_flash_req_data_size, io_flash_req_data_burstlen, io_flash_req_addr, io_flash_req_inst_label}, {1'b1, exp_req});
      end
      io_flash_req_ready = 1;
      step();
      io_flash_req_ready = 0;
      #1;
      total++;
      if ({io_flash_req_valid, io_dchan_req_ready, io_cchan_req_ready} !== 3'b000) begin
        bad++; $display("FAIL arb_busy t=%0d got=%b want=000", t, {io_flash_req_valid, io_dchan_req_ready, io_cchan_req_ready});
      end
      er = 1'($urandom); ca = 2'($urandom);
      io_flash_resp_valid = 1; io_flash_resp_error = er; io_flash_resp_cause = ca;
      step();
      io_flash_resp_valid = 0; io_flash_resp_error = 0; io_flash_resp_cause = 0;
      #1;
      exp_resp = w ? {1'b1, er, ca, 4'b0000} : {4'b0000, 1'b1, er, ca};
      total++;
      if (resp_obs() !== exp_resp) begin
        bad++; $display("FAIL arb_resp t=%0d got=%b want=%b", t, resp_obs(), exp_resp);
      end
    end
    io_dchan_req_valid = 0; io_cchan_req_valid = 0;
    step();
  endtask

  task automatic test_steering();
    logic [31:0] wd, rd;
    wd = $urandom; rd = $urandom;
    io_dchan_req_valid = 1; rand_d();
    #1;
    void'(model_pick(1'b1, 1'b0));
    step();
    io_dchan_req_valid = 0;
    io_tdata_fifo_full = 0;
    io_cchan_tdata_fifo_wen = 1; io_cchan_tdata_fifo_wdata = 32'hDEADBEEF; io_dchan_tdata_fifo_wen = 0;
    #1;
    total++;
    if ({io_tdata_fifo_wen, io_cchan_tdata_fifo_full, io_dchan_tdata_fifo_full} !== 3'b010) begin
      bad++; $display("FAIL steer_block_cchan got wen/cfull/dfull=%b want=010", {io_tdata_fifo_wen, io_cchan_tdata_fifo_full, io_dchan_tdata_fifo_full});
    end
    io_dchan_tdata_fifo_wen = 1; io_dchan_tdata_fifo_wdata = wd;
    #1;
    total++;
    if ({io_tdata_fifo_wen, io_tdata_fifo_wdata} !== {1'b1, wd}) begin
      bad++; $display("FAIL steer_dchan_wr got=%b/%h want=1/%h", io_tdata_fifo_wen, io_tdata_fifo_wdata, wd);
    end
    io_tdata_fifo_full = 1;
    io_rdata_fifo_rdata = rd; io_rdata_fifo_empty = 0;
    io_cchan_rdata_fifo_ren = 1; io_dchan_rdata_fifo_ren = 0;
    #1;
    total++;
    if ({io_dchan_tdata_fifo_full, io_rdata_fifo_ren, io_cchan_rdata_fifo_empty, io_dchan_rdata_fifo_empty, io_dchan_rdata_fifo_rdata, io_cchan_rdata_fifo_rdata}
        !== {4'b1010, rd, rd}) begin
      bad++; $display("FAIL steer_rd got dfull/ren/cemp/demp=%b rd=%h/%h want 1010 rd=%h", {io_dchan_tdata_fifo_full, io_rdata_fifo_ren, io_cchan_rdata_fifo_empty, io_dchan_rdata_fifo_empty},
                      io_dchan_rdata_fifo_rdata, io_cchan_rdata_fifo_rdata, rd);
    end
    io_dchan_rdata_fifo_ren = 1;
    io_flash_req_ready = 1;
    #1;
    total++;
    if (io_rdata_fifo_ren !== 1'b1) begin
      bad++; $display("FAIL steer_dchan_ren got=%b want=1", io_rdata_fifo_ren);
    end
    step();
    io_flash_req_ready = 0;
    io_flash_resp_valid = 1; io_flash_resp_error = 1; io_flash_resp_cause = 2'b01;
    step();
    io_flash_resp_valid = 0; io_flash_resp_error = 0; io_flash_resp_cause = 0;
    io_tdata_fifo_full = 0; io_rdata_fifo_empty = 0;
    #1;
    total++;
    if (resp_obs() !== 8'b1101_0000) begin
      bad++; $display("FAIL steer_resp got=%b want=11010000", resp_obs());
    end
    total++;
    if ({io_tdata_fifo_wen, io_rdata_fifo_ren, io_dchan_tdata_fifo_full, io_cchan_tdata_fifo_full, io_dchan_rdata_fifo_empty, io_cchan_rdata_fifo_empty} !== 6'b001111) begin
      bad++; $display("FAIL steer_idle got=%b want=001111", {io_tdata_fifo_wen, io_rdata_fifo_ren, io_dchan_tdata_fifo_full, io_cchan_tdata_fifo_full, io_dchan_rdata_fifo_empty, io_cchan_rdata_fifo_empty});
    end
    io_dchan_tdata_fifo_wen = 0; io_cchan_tdata_fifo_wen = 0;
    io_dchan_rdata_fifo_ren = 0; io_cchan_rdata_fifo_ren = 0;
    step();
  endtask

  task automatic test_stall();
    bit w;
    logic [48:0] exp_req, got;
    io_dchan_req_valid = 1; io_cchan_req_valid = 1; rand_d(); rand_c();
    #1;
    w = model_pick(1'b1, 1'b1);
    exp_req = w ? {io_dchan_req_inst, io_dchan_req_data_size, io_dchan_req_data_burstlen, io_dchan_req_addr, 1'b1}
                : {io_cchan_req_inst, io_cchan_req_data_size, io_cchan_req_data_burstlen, io_cchan_req_addr, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step();
      rand_d(); rand_c();
      #1;
      got = {io_flash_req_inst, io_flash_req_data_size, io_flash_req_data_burstlen, io_flash_req_addr, io_flash_req_inst_label};
      total++;
      if ({io_flash_req_valid, got, io_dchan_req_ready, io_cchan_req_ready} !== {1'b1, exp_req, 2'b00}) begin
        bad++; $display("FAIL stall_hold i=%0d got v=%b req=%h rdy=%b want v=1 req=%h rdy=00", i, io_flash_req_valid, got,
                        {io_dchan_req_ready, io_cchan_req_ready}, exp_req);
      end
    end
    io_flash_req_ready = 1;
    step();
    io_flash_req_ready = 0;
    io_dchan_req_valid = 0; io_cchan_req_valid = 0;
    io_flash_resp_valid = 1;
    step();
    io_flash_resp_valid = 0;
    #1;
    total++;
    if ({io_dchan_resp_valid, io_cchan_resp_valid} !== {w, !w}) begin
      bad++; $display("FAIL stall_resp got=%b want=%b", {io_dchan_resp_valid, io_cchan_resp_valid}, {w, !w});
    end
    step();
  endtask

  task automatic test_reset_busy();
    io_dchan_req_valid = 1; rand_d();
    step();
    io_dchan_req_valid = 0; io_flash_req_ready = 1;
    step();
    io_flash_req_ready = 0;
    io_dchan_tdata_fifo_wen = 1; io_dchan_rdata_fifo_ren = 1;
    reset = 1;
    step();
    reset = 0;
    streak = 0;
    #1;
    total++;
    if (rst_obs() !== RST_EXP) begin
      bad++; $display("FAIL reset_busy got=%h want=%h", rst_obs(), RST_EXP);
    end
    io_flash_resp_valid = 1;
    step();
    io_flash_resp_valid = 0;
    #1;
    total++;
    if ({io_dchan_resp_valid, io_cchan_resp_valid} !== 2'b00) begin
      bad++; $display("FAIL idle_resp_ignored got=%b want=00", {io_dchan_resp_valid, io_cchan_resp_valid});
    end
    io_cchan_req_valid = 1;
    #1;
    total++;
    if (io_cchan_req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_busy_idle_grant got=%b want=1", io_cchan_req_ready);
    end
    apply_reset();
  endtask

`ifdef QSPI_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int seen, aborts;
    seen = -1; aborts = 0;
    io_cchan_req_valid = 1; rand_c();
    step();
    io_cchan_req_valid = 0; io_flash_req_ready = 1;
    step();
    io_flash_req_ready = 0;
    // now in the first BUSY cycle
    for (int j = 1; j <= 3 * TMO && seen < 0; j++) begin
      step();
      if (io_flash_abort === 1'b1) aborts++;
      if (io_cchan_resp_valid === 1'b1) begin
        seen = j;
        total++;
        if ({io_cchan_resp_error, io_cchan_resp_cause, io_flash_abort, io_dchan_resp_valid} !== 5'b11110) begin
          bad++; $display("FAIL timeout_resp got err/cause/abort/d=%b want=11110", {io_cchan_resp_error, io_cchan_resp_cause, io_flash_abort, io_dchan_resp_valid});
        end
      end
    end
    total++;
    if (seen != TMO) begin
      bad++; $display("FAIL timeout_latency got=%0d want=%0d", seen, TMO);
    end
    step();
    total++;
    if ({aborts, io_flash_abort} !== {32'd1, 1'b0}) begin
      bad++; $display("FAIL timeout_abort_pulse got aborts=%0d now=%b want 1/0", aborts, io_flash_abort);
    end
    // Real response in the last BUSY cycle beats the timeout.
    io_cchan_req_valid = 1; rand_c();
    step();
    io_cchan_req_valid = 0; io_flash_req_ready = 1;
    step();
    io_flash_req_ready = 0;
    for (int j = 1; j < TMO; j++) step();
    io_flash_resp_valid = 1; io_flash_resp_error = 0; io_flash_resp_cause = 2'b10;
    step();
    io_flash_resp_valid = 0; io_flash_resp_cause = 0;
    #1;
    total++;
    if ({io_cchan_resp_valid, io_cchan_resp_error, io_cchan_resp_cause, io_flash_abort} !== 5'b10100) begin
      bad++; $display("FAIL timeout_real_wins got=%b want=10100", {io_cchan_resp_valid, io_cchan_resp_error, io_cchan_resp_cause, io_flash_abort});
    end
    step();
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_cchan();
    apply_reset();
    test_arbitration(1'b0, 12);
    test_arbitration(1'b1, 40);
    test_steering();
    test_stall();
    test_reset_busy();
`ifdef QSPI_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
